// File: rtl/ula_arbiter.sv
// Round-robin arbiter that shares one combinational ULA between two requesters.
// Operands are registered onto the ULA, and each result is captured back with a one-cycle ack.
module ula_arbiter #(
  parameter int W    = 4,
  parameter int SELW = 2
) (
  input  logic            iCLK,
  input  logic            iRST_N,
  input  logic            req0,
  input  logic [W-1:0]    a0,
  input  logic [W-1:0]    b0,
  input  logic [SELW-1:0] sel0,
  output logic            ack0,
  output logic [W-1:0]    res0,
  output logic            ovrf0,
  input  logic            req1,
  input  logic [W-1:0]    a1,
  input  logic [W-1:0]    b1,
  input  logic [SELW-1:0] sel1,
  output logic            ack1,
  output logic [W-1:0]    res1,
  output logic            ovrf1,
  output logic [W-1:0]    ula_a,
  output logic [W-1:0]    ula_b,
  output logic [SELW-1:0] ula_sel,
  input  logic [W-1:0]    ula_res,
  input  logic            ula_ovrf,
  output logic [1:0]      gnt,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            ack0_q, ack0_d, ack1_q, ack1_d;
  logic [W-1:0]    res0_q, res0_d, res1_q, res1_d;
  logic            ovrf0_q, ovrf0_d, ovrf1_q, ovrf1_d;
  logic [W-1:0]    ula_a_q, ula_a_d, ula_b_q, ula_b_d;
  logic [SELW-1:0] ula_sel_q, ula_sel_d;
  logic            grant_s, win_s;

  // Next-state and output logic; requests only matter while IDLE.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    res0_d    = res0_q;
    res1_d    = res1_q;
    ovrf0_d   = ovrf0_q;
    ovrf1_d   = ovrf1_q;
    ula_a_d   = ula_a_q;
    ula_b_d   = ula_b_q;
    ula_sel_d = ula_sel_q;
    grant_s   = 1'b0;
    win_s     = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the winner is whoever was not served last.
        if (req0 && req1) begin
          grant_s = 1'b1;
          win_s   = ~last_q;
        end else if (req0) begin
          grant_s = 1'b1;
          win_s   = 1'b0;
        end else if (req1) begin
          grant_s = 1'b1;
          win_s   = 1'b1;
        end else begin
          grant_s = 1'b0;
          win_s   = 1'b0;
        end
        if (grant_s) begin
          state_d   = EXEC;
          last_d    = win_s;
          busy_d    = 1'b1;
          gnt_d     = win_s ? 2'b10 : 2'b01;
          ula_a_d   = win_s ? a1 : a0;
          ula_b_d   = win_s ? b1 : b0;
          ula_sel_d = win_s ? sel1 : sel0;
        end else begin
          busy_d = 1'b0;
          gnt_d  = 2'b00;
        end
      end
      EXEC: begin
        state_d = ACK;
        if (gnt_q[1]) begin
          res1_d  = ula_res;
          ovrf1_d = ula_ovrf;
          ack1_d  = 1'b1;
        end else begin
          res0_d  = ula_res;
          ovrf0_d = ula_ovrf;
          ack0_d  = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; last_q resets to 1 so requester 0 wins first.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 2'b00;
      busy_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      res0_q    <= {W{1'b0}};
      res1_q    <= {W{1'b0}};
      ovrf0_q   <= 1'b0;
      ovrf1_q   <= 1'b0;
      ula_a_q   <= {W{1'b0}};
      ula_b_q   <= {W{1'b0}};
      ula_sel_q <= {SELW{1'b0}};
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
      ovrf0_q   <= ovrf0_d;
      ovrf1_q   <= ovrf1_d;
      ula_a_q   <= ula_a_d;
      ula_b_q   <= ula_b_d;
      ula_sel_q <= ula_sel_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign res0    = res0_q;
  assign res1    = res1_q;
  assign ovrf0   = ovrf0_q;
  assign ovrf1   = ovrf1_q;
  assign ula_a   = ula_a_q;
  assign ula_b   = ula_b_q;
  assign ula_sel = ula_sel_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a behavioural ULA stand-in (00 add, 01 sub, 10 and, 11 or).
module tb_ula_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
  logic [1:0] sel0 = 2'd0, sel1 = 2'd0;
  logic       ack0, ack1, ovrf0, ovrf1, busy;
  logic [3:0] res0, res1, ula_a, ula_b;
  logic [1:0] ula_sel, gnt;
  logic [3:0] ula_res;
  logic       ula_ovrf;

  int errors = 0;
  int checks = 0;
  int cnt0, cnt1;

  always #5 clk = ~clk;

  ula_arbiter #(.W(4), .SELW(2)) dut (
    .iCLK(clk), .iRST_N(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .sel0(sel0), .ack0(ack0), .res0(res0), .ovrf0(ovrf0),
    .req1(req1), .a1(a1), .b1(b1), .sel1(sel1), .ack1(ack1), .res1(res1), .ovrf1(ovrf1),
    .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel), .ula_res(ula_res), .ula_ovrf(ula_ovrf),
    .gnt(gnt), .busy(busy)
  );

  // ULA stand-in: signed overflow for add/sub, none for logic ops.
  always_comb begin
    ula_res  = 4'd0;
    ula_ovrf = 1'b0;
    case (ula_sel)
      2'b00: begin
        ula_res  = ula_a + ula_b;
        ula_ovrf = (ula_a[3] == ula_b[3]) && (ula_res[3] != ula_a[3]);
      end
      2'b01: begin
        ula_res  = ula_a - ula_b;
        ula_ovrf = (ula_a[3] != ula_b[3]) && (ula_res[3] != ula_a[3]);
      end
      2'b10: ula_res = ula_a & ula_b;
      2'b11: ula_res = ula_a | ula_b;
      default: ula_res = 4'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, {6'd0, ack1, ack0}, 8'h00);
    chk({tag, "_gnt_busy"}, {5'd0, busy, gnt}, 8'h00);
    chk({tag, "_res"}, {res1, res0}, 8'h00);
    chk({tag, "_ovrf"}, {6'd0, ovrf1, ovrf0}, 8'h00);
    chk({tag, "_ula"}, {ula_a, ula_b}, 8'h00);
    chk({tag, "_ula_sel"}, {6'd0, ula_sel}, 8'h00);
  endtask

  initial begin
    // Reset state
    #2;
    chk_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;

    // Single op 3+5 on requester 0
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd5; sel0 = 2'b00;
    step();
    chk("t1_gnt", {6'd0, gnt}, 8'h01);
    chk("t1_busy_exec", {7'd0, busy}, 8'h01);
    chk("t1_ula_ops", {ula_a, ula_b}, 8'h35);
    chk("t1_noack", {6'd0, ack1, ack0}, 8'h00);
    req0 = 1'b0;
    step();
    chk("t1_ack", {6'd0, ack1, ack0}, 8'h01);
    chk("t1_res0", {3'd0, ovrf0, res0}, 8'h18);
    chk("t1_busy_ack", {5'd0, busy, gnt}, 8'h05);
    step();
    chk("t1_idle", {3'd0, busy, ack1, ack0, gnt}, 8'h00);
    chk("t1_res0_hold", {3'd0, ovrf0, res0}, 8'h18);

    // Simultaneous first requests after reset: requester 0 first
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst2");
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 4'd2; b0 = 4'd1;
    req1 = 1'b1; a1 = 4'd4; b1 = 4'd4; sel1 = 2'b00;
    step();
    chk("t2_gnt0", {6'd0, gnt}, 8'h01);
    step();
    chk("t2_ack0", {6'd0, ack1, ack0}, 8'h01);
    chk("t2_res0", {3'd0, ovrf0, res0}, 8'h03);
    req0 = 1'b0;
    step();
    chk("t2_ack0_drop", {6'd0, ack1, ack0}, 8'h00);
    step();
    chk("t2_gnt1", {6'd0, gnt}, 8'h02);
    chk("t2_noack", {6'd0, ack1, ack0}, 8'h00);
    step();
    chk("t2_ack1", {6'd0, ack1, ack0}, 8'h02);
    chk("t2_res1", {3'd0, ovrf1, res1}, 8'h18);
    req1 = 1'b0;
    step();
    chk("t2_ack1_drop", {6'd0, ack1, ack0}, 8'h00);

    // Sustained contention: six ops alternate 0,1,0,1,0,1
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd2; sel0 = 2'b00;
    req1 = 1'b1; a1 = 4'd6; b1 = 4'd2; sel1 = 2'b01;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t3_gnt%0d", i), {6'd0, gnt}, (i % 2 == 0) ? 8'h01 : 8'h02);
      chk($sformatf("t3_sel%0d", i), {6'd0, ula_sel}, (i % 2 == 0) ? 8'h00 : 8'h01);
      step();
      chk($sformatf("t3_ack%0d", i), {6'd0, ack1, ack0}, (i % 2 == 0) ? 8'h01 : 8'h02);
      if (ack0) cnt0++;
      if (ack1) cnt1++;
      if (i == 5) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      step();
    end
    chk("t3_cnt0", cnt0[7:0], 8'd3);
    chk("t3_cnt1", cnt1[7:0], 8'd3);
    chk("t3_results", {res1, res0}, 8'h43);

    // Operand isolation: 5+2 on requester 1, then 1+1 on requester 0
    req1 = 1'b1; a1 = 4'd5; b1 = 4'd2; sel1 = 2'b00;
    step();
    chk("t4_gnt1", {6'd0, gnt}, 8'h02);
    step();
    chk("t4_res1", {3'd0, ovrf1, res1}, 8'h07);
    req1 = 1'b0;
    step();
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd1; sel0 = 2'b00;
    step();
    chk("t4_gnt0", {6'd0, gnt}, 8'h01);
    step();
    chk("t4_ack0", {6'd0, ack1, ack0}, 8'h01);
    chk("t4_res0", {3'd0, ovrf0, res0}, 8'h02);
    req0 = 1'b0;
    step();
    step();
    chk("t4_res1_kept", {3'd0, ovrf1, res1}, 8'h07);
    chk("t4_ula_hold", {ula_a, ula_b}, 8'h11);

    // Reset during EXEC: operation lost, no ack
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd3;
    step();
    chk("t5_gnt", {6'd0, gnt}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    step();
    chk("t5_noack", {6'd0, ack1, ack0}, 8'h00);
    rst_n = 1'b1;
    req0 = 1'b0;
    req1 = 1'b1; a1 = 4'd6; b1 = 4'd1; sel1 = 2'b00;
    step();
    chk("t5_gnt1", {6'd0, gnt}, 8'h02);
    step();
    chk("t5_ack1", {6'd0, ack1, ack0}, 8'h02);
    chk("t5_res1", {3'd0, ovrf1, res1}, 8'h07);
    req1 = 1'b0;
    step();

    // Late drop: req0 released during EXEC still completes
    req0 = 1'b1; a0 = 4'd7; b0 = 4'd1; sel0 = 2'b00;
    step();
    chk("t6_gnt", {6'd0, gnt}, 8'h01);
    req0 = 1'b0;
    step();
    chk("t6_ack0", {6'd0, ack1, ack0}, 8'h01);
    chk("t6_res0", {3'd0, ovrf0, res0}, 8'h18);
    step();
    chk("t6_idle", {3'd0, busy, ack1, ack0, gnt}, 8'h00);
    step();
    chk("t6_idle2", {3'd0, busy, ack1, ack0, gnt}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
